// File: rtl/pcacc_pkg.sv
// Shared types and helpers for the popcount stream accumulator.
// Provides the FSM state type, the popcount width helper and the saturating clamp.
package pcacc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bits needed to hold a popcount of w inputs (0..w).
  function automatic int pc_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic longint clamp_acc(input longint v, input int unsigned w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/popcount_stream_acc_popcount_tree.sv
// Exact combinational popcount of a WIDTH-bit vector.
module popcount_tree
  import pcacc_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0]             bits,
  output logic [pc_width(WIDTH)-1:0]   count
);

  localparam int PW = pc_width(WIDTH);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + PW'(bits[i]);
    end
  end

endmodule

// File: rtl/popcount_stream_acc.sv
// Streaming ternary-neuron accumulator: sums popcount(pos) - popcount(neg) per burst.
// Define PCACC_SATURATE_EN to clamp each accumulate instead of wrapping.
module popcount_stream_acc
  import pcacc_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MAX_BEATS = 16,
  parameter int ACC_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_pos,
  input  logic [WIDTH-1:0]        in_neg,
  input  logic                    in_last,
  input  logic signed [ACC_W-1:0] cfg_thresh,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_act,
  output logic                    out_trunc
);

  localparam int PW = pc_width(WIDTH);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic [PW-1:0]           pc_pos;
  logic [PW-1:0]           pc_neg;
  state_t                  state;
  logic                    first;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] thresh_q;
  logic [CW-1:0]           beat_cnt;

  logic signed [ACC_W:0]   delta;
  logic signed [ACC_W:0]   base;
  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] thr_eff;
  logic [CW-1:0]           cnt_next;
  logic                    close;
`ifdef PCACC_SATURATE_EN
  logic signed [63:0]      sat_wide;
`endif

  popcount_tree #(.WIDTH(WIDTH)) u_pc_pos (.bits(in_pos), .count(pc_pos));
  popcount_tree #(.WIDTH(WIDTH)) u_pc_neg (.bits(in_neg), .count(pc_neg));

  assign in_ready = (state == ACC);

  always_comb begin
    delta   = $signed({{(ACC_W + 1 - PW){1'b0}}, pc_pos})
            - $signed({{(ACC_W + 1 - PW){1'b0}}, pc_neg});
    base    = first ? '0 : {acc[ACC_W-1], acc};
    sum_ext = base + delta;
`ifdef PCACC_SATURATE_EN
    sat_wide = clamp_acc(longint'(sum_ext), ACC_W);
    acc_next = sat_wide[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
    // The first beat's threshold is compared before thresh_q has captured it.
    thr_eff  = first ? cfg_thresh : thresh_q;
    cnt_next = first ? CW'(1) : beat_cnt + CW'(1);
    close    = in_last || (cnt_next == CW'(MAX_BEATS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      first     <= 1'b1;
      acc       <= '0;
      thresh_q  <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_act   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            first    <= 1'b0;
            acc      <= acc_next;
            beat_cnt <= cnt_next;
            if (first) thresh_q <= cfg_thresh;
            if (close) begin
              out_sum   <= acc_next;
              out_act   <= (acc_next >= thr_eff);
              out_trunc <= !in_last;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            first     <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
